// File: rtl/logic_shift_unit_if.sv
// ---------------------------------------------------------------------------
// logic_shift_unit_if
// Request/response bundle for the logic/shift execution unit.
//   i_valid/o_ready   : request handshake (accept = i_valid && o_ready)
//   i_arg1            : rs1, the value that is shifted
//   i_arg2            : rs2 or sign-extended immediate; low log2(WIDTH) bits
//                       give the shift amount
//   i_op              : operation select
//   o_valid/i_ready   : result handshake
//   o_result          : result, held stable while o_valid is high
//   o_busy            : operation in flight (SHIFT or DONE)
// slave  = the execution unit, master = the issuing stage / testbench.
// ---------------------------------------------------------------------------
interface logic_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_arg1;
    logic [WIDTH-1:0] i_arg2;
    logic [2:0]       i_op;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_busy;

    modport master (
        output i_valid, i_arg1, i_arg2, i_op, i_ready,
        input  o_ready, o_valid, o_result, o_busy
    );

    modport slave (
        input  i_valid, i_arg1, i_arg2, i_op, i_ready,
        output o_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/logic_shift_unit.sv
// ---------------------------------------------------------------------------
// logic_shift_unit
// Multi-cycle RV32I logic/shift unit: XOR/OR/AND in one cycle, SLL/SRL/SRA
// through an iterative shifter that moves at most STEP bits per cycle.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   bus      : logic_shift_unit_if.slave (request/result handshakes, busy)
// Op encoding: 001 XOR, 010 OR, 100 AND, 011 SLL, 101 SRL, 111 SRA;
// 000 and 110 produce 0.
// ---------------------------------------------------------------------------
module logic_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    logic_shift_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg;      // working shift register
    logic [CW-1:0]    cnt;       // remaining shift distance
    logic [2:0]       op_q;      // latched shift op
    logic [WIDTH-1:0] res_q;     // result register, drives o_result

    logic [CW-1:0]    shamt;
    logic             is_shift;
    logic             go_shift;
    logic [WIDTH-1:0] imm_res;
    logic [CW:0]      cnt_ext;
    logic [CW:0]      step_w;
    logic [CW:0]      d;
    logic [WIDTH-1:0] sh_nxt;
    logic             last_step;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_arg2_hi;
    assign unused_arg2_hi = ^bus.i_arg2[WIDTH-1:CW];

    assign shamt    = bus.i_arg2[CW-1:0];
    assign is_shift = (bus.i_op == OP_SLL) || (bus.i_op == OP_SRL) ||
                      (bus.i_op == OP_SRA);
    assign go_shift = is_shift && (shamt != '0);

    // Single-cycle result: logic ops, zero-distance shifts, illegal ops.
    always_comb begin
        imm_res = '0;
        case (bus.i_op)
            OP_XOR:                 imm_res = bus.i_arg1 ^ bus.i_arg2;
            OP_OR:                  imm_res = bus.i_arg1 | bus.i_arg2;
            OP_AND:                 imm_res = bus.i_arg1 & bus.i_arg2;
            OP_SLL, OP_SRL, OP_SRA: imm_res = bus.i_arg1;
            default:                imm_res = '0;
        endcase
    end

    // Per-cycle distance d = min(STEP, cnt). One extra bit so STEP == WIDTH
    // is representable.
    assign cnt_ext   = {1'b0, cnt};
    assign step_w    = (CW+1)'(STEP);
    assign d         = (cnt_ext < step_w) ? cnt_ext : step_w;
    assign last_step = (cnt_ext == d);

    // For SRA the MSB of sreg stays equal to the original sign bit across
    // every step, so an arithmetic shift gives the required fill.
    always_comb begin
        sh_nxt = sreg;
        case (op_q)
            OP_SLL:  sh_nxt = sreg << d;
            OP_SRA:  sh_nxt = $signed(sreg) >>> d;
            default: sh_nxt = sreg >> d;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (bus.i_valid) state_d = go_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (last_step)   state_d = S_DONE;
            S_DONE:  if (bus.i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers. res_q only changes when a result is produced, so
    // o_result holds its last value outside DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sreg  <= '0;
            cnt   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        if (go_shift) begin
                            sreg <= bus.i_arg1;
                            cnt  <= shamt;
                            op_q <= bus.i_op;
                        end else begin
                            res_q <= imm_res;
                        end
                    end
                end
                S_SHIFT: begin
                    sreg <= sh_nxt;
                    cnt  <= CW'(cnt_ext - d);
                    if (last_step) res_q <= sh_nxt;
                end
                default: ;
            endcase
        end
    end

    // All handshake outputs come from registered state only.
    assign bus.o_ready  = (state == S_IDLE);
    assign bus.o_valid  = (state == S_DONE);
    assign bus.o_busy   = (state != S_IDLE);
    assign bus.o_result = res_q;

endmodule

// File: doc/logic_shift_unit.md
# logic_shift_unit

Parametrised, multi-cycle logic/shift execution unit for the RV32I datapath. It extends the single-cycle AND/OR/XOR unit with SLL/SRL/SRA, an iterative shifter of configurable step size, and valid/ready handshakes on both sides. It sits beside the ALU in the execute stage, taking rs1 and rs2 or the sign-extended immediate, and returns one result per accepted operation.

## Interface
- WIDTH, 32: operand/result width; power of 2, at least 2.
- STEP, 4: maximum shift distance per cycle; power of 2, 1..WIDTH.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request.
- i_arg1  input  WIDTH  rs1 value; the value that is shifted.
- i_arg2  input  WIDTH  rs2 or Sign_Ext[imm]; shift amount is i_arg2[$clog2(WIDTH)-1:0].
- i_op  input  3  operation select.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  WIDTH  result.
- o_busy  output  1  high in SHIFT or DONE.

## Operation
- i_op encoding, 3'b001..3'b100 unchanged from the existing logic unit:
  - 001 XOR; 010 OR; 100 AND.
  - 011 SLL; 101 SRL; 111 SRA.
  - 000 and 110 are illegal and produce result 0.
- Accept occurs when i_valid && o_ready. i_arg1, i_arg2 and i_op are sampled only at accept.
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE: o_ready=1.
  - On an accept of a logic or illegal op, or a shift with shamt==0: register the final result and go to DONE.
  - On an accept of a shift with shamt>0: load the shift register with i_arg1, set cnt=shamt, latch the op, and go to SHIFT.
- SHIFT: each cycle, shift by d=min(STEP,cnt) and set cnt-=d.
  - SLL fills with 0. SRL fills with 0. SRA fills with the original i_arg1[WIDTH-1].
  - When the new cnt==0, go to DONE with the result registered.
- DONE: o_valid=1 and o_result holds the result.
  - When i_ready=1, go to IDLE. The result is consumed in that cycle.
  - There is no accept in DONE; o_ready=0.
- Shift amounts use only the low $clog2(WIDTH) bits of i_arg2; upper bits are ignored.
- Arithmetic is pure bitwise or shift. There is no carry or overflow, and no output flags.

## Timing
- Synchronous reset (i_rst_n=0 at an edge):
  - state=IDLE, cnt=0, shift register=0.
  - o_result=0, o_valid=0, o_busy=0.
  - o_ready=1 from the first cycle after reset.
- Reset wins over every other event. A reset in SHIFT or DONE aborts the operation; no o_valid is produced for it.
- Accept edge = cycle 0.
  - Logic, illegal, or shamt==0 shift: o_valid=1 in cycle 1.
  - Shift with shamt s>0: SHIFT lasts ceil(s/STEP) cycles, and o_valid=1 in cycle 1+ceil(s/STEP).
  - Worst case (WIDTH=32, STEP=4, s=31): o_valid in cycle 9.
- o_valid stays 1, and o_result stays stable, until the edge where i_ready=1. o_valid=0 in the following cycle.
- o_ready is registered-state-derived: o_ready = (state==IDLE). There is no combinational path from i_valid or i_ready to o_ready.
- Minimum initiation interval is latency+1 cycles; a logic op with i_ready held high takes 2 cycles.
- i_valid asserted while o_ready=0 is ignored; nothing is queued.
- o_result outside DONE holds its last value; it is 0 after reset.

## Test plan
Defaults WIDTH=32, STEP=4, i_ready=1 unless stated.
- XOR: arg1=0xF0F0_1234, arg2=0x0FF0_FFFF, op=001 -> o_result=0xFF00_EDCB, o_valid in cycle 1, o_ready=1 in cycle 2.
- SRA and shamt decode:
  - arg1=0x8000_0000, arg2=0x0000_001F, op=111 -> 0xFFFF_FFFF, o_valid in cycle 9, o_busy high in cycles 1-9.
  - SRL, arg1=0x8000_0000, arg2=0xFFFF_FFE5 (shamt 5) -> 0x0400_0000, o_valid in cycle 3.
- Zero shift and illegal op:
  - SLL, arg1=0x0000_0001, arg2=0 -> 0x0000_0001 in cycle 1.
  - op=110 with any args -> 0x0000_0000 in cycle 1.
- Backpressure: AND 0xFFFF_0000 & 0x00FF_FF00 with i_ready low for 3 cycles:
  - o_result=0x00FF_0000 stable and o_valid=1 throughout; o_ready=0.
  - A new i_valid during the stall is ignored.
  - After the i_ready=1 edge, o_valid=0 and o_ready=1.
- Reset mid-operation: start SLL, arg1=0x1, shamt 31. Drive i_rst_n=0 in cycle 4 -> next cycle o_valid=0, o_result=0, o_ready=1, o_busy=0. No stale result appears afterwards.
- Parameter sweep: STEP=1 and STEP=32 with random ops, compared to a reference model:
  - STEP=32: every shift completes at o_valid cycle 2 (shamt>0).
  - STEP=1: o_valid at cycle 1+shamt.
